audio_path_sched: RTL and testbench

//  Sample scheduler between the SPI receiver (comunication) and the effect/DAC path.

---
 rtl/audio_path_if.sv | 29 ++
 rtl/audio_path_sched.sv | 136 +++++++++++++
 tb/tb_audio_path_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/audio_path_if.sv
// Sample path bundle between the SPI receiver, the effect block and the DAC driver.
interface audio_path_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          in_valid;
  logic [15:0]                   in_sample;
  logic                          bypass;
  logic                          eff_start;
  logic [15:0]                   eff_sample;
  logic                          eff_done;
  logic [15:0]                   eff_result;
  logic                          dac_valid;
  logic [15:0]                   dac_sample;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          busy;
  logic                          overrun;
  logic                          timeout_err;
  logic                          clr_err;

  modport master (
    output in_valid, in_sample, bypass, eff_done, eff_result, clr_err,
    input  eff_start, eff_sample, dac_valid, dac_sample, fifo_level, busy, overrun, timeout_err
  );

  modport slave (
    input  in_valid, in_sample, bypass, eff_done, eff_result, clr_err,
    output eff_start, eff_sample, dac_valid, dac_sample, fifo_level, busy, overrun, timeout_err
  );
endinterface

// File: rtl/audio_path_sched.sv
// Sample scheduler: captures SPI samples, routes them through the effect (with timeout) or
// bypasses it, queues results and releases them to the DAC at the audio rate.
module audio_path_sched #(
  parameter int clock_max   = 25_000_000,
  parameter int audio_clk   = 400,
  parameter int EFF_TIMEOUT = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk_25mhz,
  input  logic         reset,
  audio_path_if.slave  bus
);
  localparam int TICK_DIV = clock_max / audio_clk;
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int EW = (EFF_TIMEOUT > 2) ? $clog2(EFF_TIMEOUT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_PUSH   = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [15:0]                  cap_q, cap_d;
  logic [15:0]                  push_data_q, push_data_d;
  logic [EW-1:0]                timer_q, timer_d;
  logic [TW-1:0]                tick_q, tick_d;
  logic [FIFO_DEPTH-1:0][15:0]  mem_q, mem_d;
  logic [AW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [LW-1:0]                level_q, level_d;
  logic [15:0]                  dac_sample_q, dac_sample_d;
  logic                         dac_valid_q, dac_valid_d;
  logic                         overrun_q, overrun_d;
  logic                         timeout_q, timeout_d;
  logic                         tick, pop, push, ov_set, to_set;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    push_data_d = push_data_q;
    timer_d     = timer_q;
    to_set      = 1'b0;
    ov_set      = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) begin
        cap_d = bus.in_sample;
        if (bus.bypass) begin
          push_data_d = bus.in_sample;
          state_d     = S_PUSH;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse on the final timer cycle still counts as a normal completion.
        if (bus.eff_done) begin
          push_data_d = bus.eff_result;
          state_d     = S_PUSH;
        end else if (timer_q == EW'(EFF_TIMEOUT - 1)) begin
          push_data_d = cap_q;
          to_set      = 1'b1;
          state_d     = S_PUSH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.in_valid && state_q != S_IDLE) ov_set = 1'b1;

    // Pop is decided on the current level, so a pop frees room for a same-cycle push.
    tick   = (tick_q == TW'(TICK_DIV - 1));
    tick_d = tick ? '0 : tick_q + 1'b1;
    pop    = tick && (level_q != '0);
    push   = (state_q == S_PUSH) && ((level_q != LW'(FIFO_DEPTH)) || pop);
    if (state_q == S_PUSH && !push) ov_set = 1'b1;

    mem_d = mem_q;
    if (push) mem_d[tail_q] = push_data_q;
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    level_d = level_q + LW'(push) - LW'(pop);

    dac_valid_d  = pop;
    dac_sample_d = pop ? mem_q[head_q] : dac_sample_q;
    overrun_d    = (overrun_q & ~bus.clr_err) | ov_set;
    timeout_d    = (timeout_q & ~bus.clr_err) | to_set;
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cap_q        <= '0;
      push_data_q  <= '0;
      timer_q      <= '0;
      tick_q       <= '0;
      mem_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      level_q      <= '0;
      dac_sample_q <= '0;
      dac_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      push_data_q  <= push_data_d;
      timer_q      <= timer_d;
      tick_q       <= tick_d;
      mem_q        <= mem_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      level_q      <= level_d;
      dac_sample_q <= dac_sample_d;
      dac_valid_q  <= dac_valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.eff_start   = (state_q == S_LAUNCH);
  assign bus.eff_sample  = cap_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.fifo_level  = level_q;
  assign bus.dac_valid   = dac_valid_q;
  assign bus.dac_sample  = dac_sample_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_audio_path_sched.sv
// Bench for audio_path_sched: directed scenarios plus random traffic against a
// transaction-level model (push times derived from latency rules, queue for the FIFO).
module tb_audio_path_sched;
  localparam int TICK_DIV = 10;
  localparam int TMO      = 8;
  localparam int DEPTH    = 4;

  logic clk_25mhz = 1'b0;
  logic reset     = 1'b1;
  always #5 clk_25mhz = ~clk_25mhz;

  audio_path_if #(.FIFO_DEPTH(DEPTH)) bus ();

  audio_path_sched #(
    .clock_max(1000), .audio_clk(100), .EFF_TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .reset    (reset),
    .bus      (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // model state: cycle index since reset release, scheduled events, expected outputs
  int          k;
  int          busy_lo, busy_hi, s_cyc, done_cyc, push_cyc, to_cyc;
  logic [15:0] push_val, res_val, e_cap, e_dac;
  logic        e_dv, e_ov, e_to;
  logic [15:0] q[$];
  int          force_d;
  bit          force_res_en;
  logic [15:0] force_res;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; busy_lo = -100; busy_hi = -100; s_cyc = -100; done_cyc = -100;
    push_cyc = -100; to_cyc = -100; push_val = '0; res_val = '0;
    q.delete(); e_cap = '0; e_dac = '0; e_dv = 0; e_ov = 0; e_to = 0;
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.bypass = 0; bus.in_sample = '0;
    bus.eff_done = 0; bus.eff_result = '0; bus.clr_err = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_eff_start",  32'(bus.eff_start),   32'd0);
    chk("rst_eff_sample", 32'(bus.eff_sample),  32'd0);
    chk("rst_dac_valid",  32'(bus.dac_valid),   32'd0);
    chk("rst_dac_sample", 32'(bus.dac_sample),  32'd0);
    chk("rst_fifo_level", 32'(bus.fifo_level),  32'd0);
    chk("rst_busy",       32'(bus.busy),        32'd0);
    chk("rst_overrun",    32'(bus.overrun),     32'd0);
    chk("rst_timeout",    32'(bus.timeout_err), 32'd0);
    @(posedge clk_25mhz); @(posedge clk_25mhz); #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(bit iv, bit byp, logic [15:0] smp, bit clr, bit spur);
    int d;
    bit in_win, ov_set, to_set;
    in_win = (k >= s_cyc + 1) && (k <= s_cyc + TMO);
    bus.in_valid = iv; bus.bypass = byp; bus.in_sample = smp; bus.clr_err = clr;
    bus.eff_result = 16'($urandom);
    bus.eff_done = (k == done_cyc) || (spur && !in_win);
    if (k == done_cyc) bus.eff_result = res_val;
    @(negedge clk_25mhz);
    chk("eff_start",   32'(bus.eff_start),   32'(k == s_cyc));
    chk("eff_sample",  32'(bus.eff_sample),  32'(e_cap));
    chk("busy",        32'(bus.busy),        32'(k >= busy_lo && k <= busy_hi));
    chk("fifo_level",  32'(bus.fifo_level),  32'(q.size()));
    chk("dac_valid",   32'(bus.dac_valid),   32'(e_dv));
    chk("dac_sample",  32'(bus.dac_sample),  32'(e_dac));
    chk("overrun",     32'(bus.overrun),     32'(e_ov));
    chk("timeout_err", 32'(bus.timeout_err), 32'(e_to));

    ov_set = 0;
    to_set = (k == to_cyc);
    if (iv) begin
      if (k >= busy_lo && k <= busy_hi) ov_set = 1;
      else begin
        e_cap = smp; busy_lo = k + 1;
        if (byp) begin
          push_cyc = k + 1; push_val = smp; busy_hi = k + 1;
        end else begin
          s_cyc = k + 1;
          d = (force_d > 0) ? force_d : int'($urandom_range(TMO + 3, 1));
          if (d <= TMO) begin
            done_cyc = s_cyc + d;
            res_val  = force_res_en ? force_res : 16'($urandom);
            push_cyc = done_cyc + 1; push_val = res_val;
          end else begin
            push_cyc = s_cyc + TMO + 1; push_val = smp; to_cyc = s_cyc + TMO;
          end
          busy_hi = push_cyc;
        end
      end
    end
    e_dv = 0;
    if ((k % TICK_DIV) == TICK_DIV - 1 && q.size() > 0) begin
      e_dv = 1; e_dac = q.pop_front();
    end
    if (k == push_cyc) begin
      if (q.size() < DEPTH) q.push_back(push_val);
      else ov_set = 1;
    end
    e_ov = (e_ov && !clr) || ov_set;
    e_to = (e_to && !clr) || to_set;
    @(posedge clk_25mhz); #1;
    k++;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    force_d = 0; force_res_en = 0; force_res = '0;
    model_reset();
    do_reset();

    // bypass single sample
    step(1, 1, 16'h1234, 0, 0); idle(14);
    // effect returns after five cycles
    force_d = 5; force_res_en = 1; force_res = 16'h7F00;
    step(1, 0, 16'h00FF, 0, 0); idle(22);
    // effect never answers: timeout fallback, then clear
    force_d = 99;
    step(1, 0, 16'h00FF, 0, 0); idle(22);
    step(0, 0, 16'h0, 1, 0); idle(2);
    force_d = 0; force_res_en = 0;

    // five bypass samples between ticks: FIFO fills, fifth dropped
    do_reset();
    idle(9);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 16'(i + 1), 0, 0);
      if (i < 4) idle(1);
    end
    idle(60);

    // sample arriving while the effect is busy is dropped
    force_d = 6;
    step(1, 0, 16'h1111, 0, 0); idle(3);
    step(1, 1, 16'hAAAA, 0, 0); idle(30);

    // reset in WAIT_EFF with two entries queued; late done afterwards
    do_reset();
    step(1, 1, 16'h0011, 0, 0); idle(1);
    step(1, 1, 16'h0022, 0, 0); idle(1);
    force_d = 99;
    step(1, 0, 16'h0033, 0, 0); idle(3);
    do_reset();
    force_d = 0;
    step(0, 0, 16'h0, 0, 1); idle(20);

    // random traffic at three input rates
    for (int ph = 0; ph < 6; ph++) begin
      int pct;
      pct = (ph % 3 == 0) ? 50 : ((ph % 3 == 1) ? 15 : 5);
      if (ph == 3) do_reset();
      for (int c = 0; c < 400; c++) begin
        step($urandom_range(99, 0) < pct, $urandom_range(1, 0) == 1, 16'($urandom),
             $urandom_range(99, 0) < 3, $urandom_range(99, 0) < 10);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
